// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver.
//   states_t      : 2-bit FSM state type with S_IDLE/S_START/S_DATA/S_STOP
//   c_databits    : data bits per frame
//   timer_limit() : clocks per bit from system clock and baud rate
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef logic [1:0] states_t;

    localparam states_t S_IDLE  = 2'd0;
    localparam states_t S_START = 2'd1;
    localparam states_t S_DATA  = 2'd2;
    localparam states_t S_STOP  = 2'd3;

    localparam int c_databits = 8;

    // Clocks per bit. Callers must keep the result >= 2.
    function automatic int timer_limit(input int clkfreq, input int baudrate);
        return clkfreq / baudrate;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period counter. Counts 0..c_timerlim-1 and wraps to 0 on terminal count.
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset
//   clear_i : hold the count at zero
//   tc_o    : high during the last clock of each bit period
// -----------------------------------------------------------------------------
module uart_baud_cnt #(
    parameter int c_timerlim = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tc_o
);

    localparam int c_w = $clog2(c_timerlim);
    localparam logic [c_w-1:0] c_last = c_w'(c_timerlim - 1);

    logic [c_w-1:0] count_q;

    assign tc_o = (count_q == c_last);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clear_i || tc_o) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8N1/8N2 UART transmitter with a one-byte holding register so frames can be
// sent back-to-back without an idle bit between them.
//   clk_i          : system clock, rising edge
//   rst_i          : asynchronous active-high reset
//   tx_din_i       : byte to send, LSB first
//   tx_valid_i     : producer has a byte on tx_din_i
//   tx_ready_o     : holding register empty
//   tx_o           : registered serial line, idles high
//   tx_done_tick_o : one-cycle pulse during the last clock of the final stop bit
//   tx_active_o    : high while a frame is on the line
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int c_clkfreq  = 100_000_000,
    parameter int c_baudrate = 10_000_000,
    parameter int c_stopbits = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_din_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_o,
    output logic       tx_done_tick_o,
    output logic       tx_active_o
);

    localparam int c_timerlim = timer_limit(c_clkfreq, c_baudrate);

    states_t    state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       done_d;
    logic       tx_q, done_q, active_q;
    logic       handshake, load, timer_tc;

    uart_baud_cnt #(
        .c_timerlim (c_timerlim)
    ) u_baud_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (state_q == S_IDLE),
        .tc_o    (timer_tc)
    );

    assign tx_ready_o     = !hold_valid_q;
    assign handshake      = tx_valid_i && tx_ready_o;
    assign tx_o           = tx_q;
    assign tx_done_tick_o = done_q;
    assign tx_active_o    = active_q;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        bitcnt_d     = bitcnt_q;
        done_d       = 1'b0;
        load         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hold_valid_q) begin
                    load    = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (timer_tc) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (timer_tc) begin
                    shreg_d = shreg_q >> 1;
                    if (bitcnt_q == 3'(c_databits - 1)) begin
                        bitcnt_d = '0;
                        state_d  = S_STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // bitcnt doubles as the stop-bit counter for 8N2.
                if (timer_tc) begin
                    if (bitcnt_q == 3'(c_stopbits - 1)) begin
                        bitcnt_d = '0;
                        done_d   = 1'b1;
                        if (hold_valid_q) begin
                            load    = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            shreg_d      = hold_q;
            hold_valid_d = 1'b0;
        end
        // A handshake in the same cycle as a transfer refills the holding
        // register, so it is applied last.
        if (handshake) begin
            hold_d       = tx_din_i;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            bitcnt_q     <= '0;
            tx_q         <= 1'b1;
            done_q       <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            bitcnt_q     <= bitcnt_d;
            done_q       <= done_d;
            // Line and activity flag decode the current state, which puts the
            // start bit two clocks after the accepting edge.
            active_q     <= (state_q != S_IDLE);
            case (state_q)
                S_START: tx_q <= 1'b0;
                S_DATA:  tx_q <= shreg_q[0];
                default: tx_q <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Scoreboard bench for uart_tx. dut0 runs 8N1 and dut1 runs 8N2, both at ten
// clocks per bit. Stimulus pushes each accepted byte with its expected start
// cycle; one monitor per DUT pops entries and checks the frame cycle by cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int L     = 10;
    localparam int FLEN0 = 10 * L;
    localparam int FLEN1 = 11 * L;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din0, din1;
    logic       valid0, valid1;
    logic       ready0, ready1, tx0, tx1, done0, done1, active0, active1;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         done_cnt0 = 0;
    int         done_cnt1 = 0;
    int         first_start;
    bit         mon_busy0 = 1'b0;
    bit         mon_busy1 = 1'b0;
    exp_t       exp_q0[$];
    exp_t       exp_q1[$];
    logic [7:0] stim_q[$];

    uart_tx #(.c_clkfreq(100_000_000), .c_baudrate(10_000_000), .c_stopbits(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .tx_din_i(din0), .tx_valid_i(valid0),
        .tx_ready_o(ready0), .tx_o(tx0), .tx_done_tick_o(done0), .tx_active_o(active0)
    );

    uart_tx #(.c_clkfreq(100_000_000), .c_baudrate(10_000_000), .c_stopbits(2)) dut1 (
        .clk_i(clk), .rst_i(rst), .tx_din_i(din1), .tx_valid_i(valid1),
        .tx_ready_o(ready1), .tx_o(tx1), .tx_done_tick_o(done1), .tx_active_o(active1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            if (done0 === 1'b1) done_cnt0++;
            if (done1 === 1'b1) done_cnt1++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Drives stim_q into one DUT with tx_valid held high between bytes.
    task automatic send_stream(input int sel, input bit push, input int flen);
        int   hs, n, prev;
        exp_t e;
        prev = -1_000_000;
        @(negedge clk);
        for (int j = 0; j < stim_q.size(); j++) begin
            if (sel == 0) begin din0 = stim_q[j]; valid0 = 1'b1; end
            else          begin din1 = stim_q[j]; valid1 = 1'b1; end
            n = 0;
            while (((sel == 0) ? ready0 : ready1) !== 1'b1 && n < 5000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 5000) begin
                check("hs_timeout", 1, 0);
                break;
            end
            hs = cyc + 1;
            @(negedge clk);
            check("ready_low_after_hs", int'((sel == 0) ? ready0 : ready1), 0);
            e.data  = stim_q[j];
            e.start = (hs + 2 > prev + flen) ? hs + 2 : prev + flen;
            prev    = e.start;
            if (j == 0) first_start = e.start;
            if (push) begin
                if (sel == 0) exp_q0.push_back(e);
                else          exp_q1.push_back(e);
            end
        end
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    task automatic mon_run(input int sel);
        exp_t       e;
        int         n, errs, flen, bi;
        logic [7:0] dec;
        logic       ln, dn, ac, expb;
        flen = (sel == 0) ? FLEN0 : FLEN1;
        forever begin
            @(negedge clk);
            if (((sel == 0) ? exp_q0.size() : exp_q1.size()) == 0) continue;
            e = (sel == 0) ? exp_q0[0] : exp_q1[0];
            if (sel == 0) mon_busy0 = 1'b1; else mon_busy1 = 1'b1;
            n = 0;
            while (((sel == 0) ? tx0 : tx1) !== 1'b0 && n < 3000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 3000) begin
                check("start_timeout", 1, 0);
            end else begin
                check("start_cycle", cyc, e.start);
                errs = 0;
                dec  = '0;
                for (int i = 0; i < flen; i++) begin
                    if (i > 0) @(negedge clk);
                    ln = (sel == 0) ? tx0 : tx1;
                    dn = (sel == 0) ? done0 : done1;
                    ac = (sel == 0) ? active0 : active1;
                    bi = i / L;
                    if (bi == 0)      expb = 1'b0;
                    else if (bi <= 8) expb = e.data[bi-1];
                    else              expb = 1'b1;
                    if (ln !== expb) errs++;
                    if (ac !== 1'b1) errs++;
                    if (dn !== (i == flen - 1)) errs++;
                    if (bi >= 1 && bi <= 8 && (i % L) == L / 2) dec[bi-1] = ln;
                end
                check("frame_line", errs, 0);
                check("byte", int'(dec), int'(e.data));
            end
            if (sel == 0) begin void'(exp_q0.pop_front()); mon_busy0 = 1'b0; end
            else          begin void'(exp_q1.pop_front()); mon_busy1 = 1'b0; end
        end
    endtask

    initial mon_run(0);
    initial mon_run(1);

    task automatic wait_idle(input int sel);
        int n;
        n = 0;
        while (n < 50000 && (((sel == 0) ? (exp_q0.size() != 0 || mon_busy0)
                                         : (exp_q1.size() != 0 || mon_busy1)))) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50000) check("idle_timeout", 1, 0);
        repeat (5) @(negedge clk);
        #1;
    endtask

    initial begin
        int errs_tx, errs_rdy, snap, n;
        rst = 1'b1;
        valid0 = 1'b0; valid1 = 1'b0;
        din0 = '0; din1 = '0;

        // Reset state, sampled while reset is still asserted.
        repeat (3) @(negedge clk);
        check("rst_tx", int'(tx0), 1);
        check("rst_ready", int'(ready0), 1);
        check("rst_done", int'(done0), 0);
        check("rst_active", int'(active0), 0);
        check("rst_tx_2stop", int'(tx1), 1);
        rst = 1'b0;

        // Single byte 0xA5: latency, bit order, 100-clock frame, one tick.
        stim_q = '{8'hA5};
        send_stream(0, 1'b1, FLEN0);
        wait_idle(0);
        check("done_cnt_single", done_cnt0, 1);

        // Back-to-back frames with valid held high.
        stim_q = '{8'h00, 8'hFF, 8'h55};
        send_stream(0, 1'b1, FLEN0);
        wait_idle(0);
        check("done_cnt_b2b", done_cnt0, 4);

        // Reset mid-simulation, then 500 idle clocks.
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        snap = done_cnt0;
        errs_tx = 0;
        errs_rdy = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1) errs_tx++;
            if (ready0 !== 1'b1) errs_rdy++;
        end
        #1;
        check("idle_tx_high", errs_tx, 0);
        check("idle_ready_high", errs_rdy, 0);
        check("idle_no_done", done_cnt0 - snap, 0);

        // All 256 byte values as one continuous stream.
        stim_q.delete();
        for (int b = 0; b < 256; b++) stim_q.push_back(8'(b));
        send_stream(0, 1'b1, FLEN0);
        wait_idle(0);
        check("done_cnt_all_bytes", done_cnt0 - snap, 256);

        // Two stop bits: 110-clock frame.
        stim_q = '{8'h3C};
        send_stream(1, 1'b1, FLEN1);
        wait_idle(1);
        check("done_cnt_2stop", done_cnt1, 1);

        // Reset during data bit 4 with a second byte waiting in hold.
        stim_q = '{8'h81, 8'h42};
        send_stream(0, 1'b0, FLEN0);
        n = 0;
        while (cyc < first_start + 52 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_bit4", int'(tx0), 0);
        check("pre_reset_ready", int'(ready0), 0);
        snap = done_cnt0;
        rst = 1'b1;
        #1;
        check("midrst_tx", int'(tx0), 1);
        check("midrst_ready", int'(ready0), 1);
        check("midrst_active", int'(active0), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        errs_tx = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || active0 !== 1'b0) errs_tx++;
        end
        #1;
        check("post_rst_no_frame", errs_tx, 0);
        check("post_rst_no_done", done_cnt0 - snap, 0);
        check("post_rst_ready", int'(ready0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
